// File: rtl/aes_round_ctrl.sv
// aes_round_ctrl: iterative AES encryption round sequencer.
// It owns the block state, the round counter and the round-key index, and
// steps one shared combinational round datapath once per clock. One block is
// processed at a time:
//   IDLE  -> accept a block
//   ROUND -> run NR rounds
//   DONE  -> hold the ciphertext until the consumer takes it
module aes_round_ctrl #(
  parameter int NR = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] plaintext,
  output logic [3:0]   rk_idx,
  input  logic [127:0] rk_data,
  output logic [127:0] dp_state,
  output logic         dp_last,
  input  logic [127:0] dp_result,
  output logic         busy,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] ciphertext
);

  typedef enum logic [1:0] {IDLE, ROUND, DONE} st_t;

  localparam logic [3:0] LAST = 4'(NR);

  st_t          st_q, st_d;
  logic [127:0] state_q, state_d;
  logic [3:0]   round_q, round_d;

  // State, round counter and FSM registers; reset drops any in-flight block.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q    <= IDLE;
      state_q <= '0;
      round_q <= '0;
    end else begin
      st_q    <= st_d;
      state_q <= state_d;
      round_q <= round_d;
    end
  end

  // Next-state and output decode.
  // The handshake outputs depend only on the registered FSM state.
  always_comb begin
    st_d      = st_q;
    state_d   = state_q;
    round_d   = round_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    dp_last   = 1'b0;
    rk_idx    = 4'd0;
    case (st_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          // The initial AddRoundKey uses round key 0.
          // rk_idx is 0 in IDLE, so rk_data already holds that key.
          state_d = plaintext ^ rk_data;
          round_d = 4'd1;
          st_d    = ROUND;
        end
      end
      ROUND: begin
        rk_idx  = round_q;
        dp_last = (round_q == LAST);
        state_d = dp_result;
        if (round_q == LAST) begin
          round_d = 4'd0;
          st_d    = DONE;
        end else begin
          round_d = round_q + 4'd1;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) st_d = IDLE;
      end
      default: st_d = IDLE;
    endcase
  end

  assign busy       = (st_q != IDLE);
  assign dp_state   = state_q;
  // Gate the ciphertext so a partially encrypted state never appears on it.
  assign ciphertext = out_valid ? state_q : '0;

endmodule

// File: tb/tb_aes_round_ctrl.sv
// tb_aes_round_ctrl: directed bench for aes_round_ctrl.
// dut0 (NR=10) is driven by a behavioural AES-128 round and key schedule.
// It is checked against the FIPS-197 vectors.
// dut1 (NR=14) uses a stub datapath: result = state + 1, with all round keys 0.
module tb_aes_round_ctrl;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // ---------------------------------------------------------------- dut0
  logic         in_valid0, in_ready0, dp_last0, busy0, out_valid0, out_ready0;
  logic [127:0] plaintext0, rk_data0, dp_state0, dp_result0, ciphertext0;
  logic [3:0]   rk_idx0;
  logic [127:0] rks [0:10];

  aes_round_ctrl #(.NR(10)) dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid0), .in_ready(in_ready0),
    .plaintext(plaintext0), .rk_idx(rk_idx0), .rk_data(rk_data0),
    .dp_state(dp_state0), .dp_last(dp_last0), .dp_result(dp_result0),
    .busy(busy0), .out_valid(out_valid0), .out_ready(out_ready0),
    .ciphertext(ciphertext0)
  );

  // ---------------------------------------------------------------- dut1
  logic         in_valid1, in_ready1, dp_last1, busy1, out_valid1, out_ready1;
  logic [127:0] plaintext1, rk_data1, dp_state1, dp_result1, ciphertext1;
  logic [3:0]   rk_idx1;

  aes_round_ctrl #(.NR(14)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(in_ready1),
    .plaintext(plaintext1), .rk_idx(rk_idx1), .rk_data(rk_data1),
    .dp_state(dp_state1), .dp_last(dp_last1), .dp_result(dp_result1),
    .busy(busy1), .out_valid(out_valid1), .out_ready(out_ready1),
    .ciphertext(ciphertext1)
  );

  assign rk_data1   = '0;
  assign dp_result1 = dp_state1 + 128'd1;

  // ------------------------------------------------------- AES model
  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = xt(a);
      b = b >> 1;
    end
    return p;
  endfunction

  // Inverse is x^254 in GF(2^8), followed by the affine transform.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] r = 8'h01;
    logic [7:0] p = x;
    logic [7:0] e = 8'hfe;
    for (int i = 0; i < 8; i++) begin
      if (e[i]) r = gmul(r, p);
      p = gmul(p, p);
    end
    return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]}
             ^ {r[3:0], r[7:4]} ^ 8'h63;
  endfunction

  // SubBytes -> ShiftRows -> MixColumns (skipped on last round); byte i at [127-8i -: 8]
  function automatic logic [127:0] aes_round(input logic [127:0] s, input logic last);
    logic [7:0] b [16];
    logic [7:0] t [16];
    logic [7:0] a0, a1, a2, a3;
    logic [127:0] o = '0;
    for (int i = 0; i < 16; i++) b[i] = sbox(s[127-8*i -: 8]);
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) t[r+4*c] = b[r+4*((c+r)%4)];
    if (!last) begin
      for (int c = 0; c < 4; c++) begin
        a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
        t[4*c]   = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
        t[4*c+1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
        t[4*c+2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
        t[4*c+3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
      end
    end
    for (int i = 0; i < 16; i++) o[127-8*i -: 8] = t[i];
    return o;
  endfunction

  assign rk_data0   = (rk_idx0 <= 4'd10) ? rks[rk_idx0] : '0;
  assign dp_result0 = aes_round(dp_state0, dp_last0) ^ rk_data0;

  task automatic expand(input logic [127:0] key);
    logic [31:0] w [44];
    logic [31:0] tmp;
    logic [7:0]  rcon = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp = {sbox(tmp[23:16]), sbox(tmp[15:8]), sbox(tmp[7:0]), sbox(tmp[31:24])}
              ^ {rcon, 24'h0};
        rcon = xt(rcon);
      end
      w[i] = w[i-4] ^ tmp;
    end
    for (int r = 0; r <= 10; r++) rks[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  // ------------------------------------------------------- checking
  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  localparam logic [127:0] KEY_B = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] KEY_C = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] PT_C  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT_C  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  // One block through dut0.
  // Checks the rk_idx/dp_last sequence and the latency.
  // Holds DONE for 'hold' cycles, pulsing in_valid, before taking the ciphertext.
  task automatic run_blk(input string tag, input logic [127:0] pt,
                         input logic [127:0] exp, input int hold);
    int j = 0;
    chk({tag, "_idle_rdy"}, 128'(in_ready0), 128'd1);
    chk({tag, "_idle_rk"}, 128'(rk_idx0), 128'd0);
    plaintext0 = pt;
    in_valid0  = 1'b1;
    @(negedge clk);
    in_valid0 = 1'b0;
    // j = edges since accept; round j+1 is in progress
    while (!out_valid0 && j < 40) begin
      chk({tag, "_rk"}, 128'(rk_idx0), 128'(j + 1));
      chk({tag, "_last"}, 128'(dp_last0), 128'(j == 9));
      chk({tag, "_rdy_busy"}, 128'({in_ready0, busy0}), 128'b01);
      @(negedge clk);
      j++;
    end
    chk({tag, "_lat"}, 128'(j), 128'd10);
    chk({tag, "_ct"}, ciphertext0, exp);
    chk({tag, "_done_rk"}, 128'({rk_idx0, dp_last0, in_ready0}), 128'd0);
    for (int h = 0; h < hold; h++) begin
      in_valid0  = (h % 2 == 0);
      plaintext0 = ~pt;
      @(negedge clk);
      chk({tag, "_hold_ct"}, ciphertext0, exp);
      chk({tag, "_hold_hs"}, 128'({in_ready0, out_valid0}), 128'b01);
    end
    in_valid0  = 1'b0;
    out_ready0 = 1'b1;
    @(negedge clk);
    out_ready0 = 1'b0;
    chk({tag, "_post"}, 128'({in_ready0, out_valid0, busy0}), 128'b100);
  endtask

  initial begin
    int j, cyc, acc, outs;
    int acc_at [2];
    logic drop;
    rst = 1'b1;
    in_valid0 = 0; out_ready0 = 0; plaintext0 = '0;
    in_valid1 = 0; out_ready1 = 0; plaintext1 = '0;
    expand(KEY_B);
    @(negedge clk);
    @(negedge clk);
    chk("rst_hs", 128'({in_ready0, out_valid0, busy0, dp_last0}), 128'b1000);
    chk("rst_rk", 128'(rk_idx0), 128'd0);
    chk("rst_state", dp_state0, 128'd0);
    chk("rst_ct", ciphertext0, 128'd0);
    chk("rst_dut1", 128'({in_ready1, out_valid1, busy1}), 128'b100);
    rst = 1'b0;
    @(negedge clk);

    // App. B, then App. C.1
    run_blk("appB", PT_B, CT_B, 0);
    expand(KEY_C);
    run_blk("appC", PT_C, CT_C, 0);

    // Backpressure: hold DONE for 20 cycles with in_valid pulses
    expand(KEY_B);
    run_blk("bp", PT_B, CT_B, 20);

    // Back-to-back with in_valid and out_ready held high.
    // The accept cycle, 10 round cycles and 1 DONE cycle put the next
    // accept 12 edges after the first.
    plaintext0 = PT_B; in_valid0 = 1'b1; out_ready0 = 1'b1;
    cyc = 0; acc = 0; outs = 0; drop = 1'b0; acc_at[0] = 0; acc_at[1] = 0;
    while (outs < 2 && cyc < 80) begin
      if (drop) in_valid0 = 1'b0;
      if (in_valid0 && in_ready0 && acc < 2) begin
        acc_at[acc] = cyc;
        acc++;
        if (acc == 2) drop = 1'b1;
      end
      if (out_valid0) begin
        chk("b2b_ct", ciphertext0, CT_B);
        outs++;
      end
      @(negedge clk);
      cyc++;
    end
    out_ready0 = 1'b0;
    in_valid0  = 1'b0;
    chk("b2b_outs", 128'(outs), 128'd2);
    chk("b2b_gap", 128'(acc_at[1] - acc_at[0]), 128'd12);
    chk("b2b_idle", 128'({in_ready0, busy0}), 128'b10);

    // Reset in the middle of round 5
    expand(KEY_C);
    plaintext0 = PT_C; in_valid0 = 1'b1;
    @(negedge clk);
    in_valid0 = 1'b0;
    j = 0;
    while (rk_idx0 != 4'd5 && j < 20) begin
      @(negedge clk);
      j++;
    end
    chk("mid_rk5", 128'(rk_idx0), 128'd5);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_hs", 128'({in_ready0, out_valid0, busy0, dp_last0}), 128'b1000);
    chk("mid_rst_st", dp_state0, 128'd0);
    chk("mid_rst_rk", 128'(rk_idx0), 128'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    run_blk("post_rst", PT_C, CT_C, 0);

    // Stub datapath, NR=14; the low half-word carries on +14
    plaintext1 = 128'h0123456789abcdef00112233445566f8;
    in_valid1  = 1'b1;
    @(negedge clk);
    in_valid1 = 1'b0;
    j = 0;
    while (!out_valid1 && j < 40) begin
      chk("stub_last", 128'(dp_last1), 128'(j == 13));
      @(negedge clk);
      j++;
    end
    chk("stub_lat", 128'(j), 128'd14);
    chk("stub_ct", ciphertext1, 128'h0123456789abcdef0011223344556706);
    out_ready1 = 1'b1;
    @(negedge clk);
    out_ready1 = 1'b0;
    chk("stub_post", 128'({in_ready1, out_valid1}), 128'b10);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
